// File: rtl/alu_pkg.sv
// Shared definitions for the issue stage and its ALU: data width and opcodes.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NAND = 2'b10,
        OP_NOR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/regfile_nx16.sv
// NREG x 16-bit register array.
// - Two combinational operand read ports and one combinational debug port.
// - Two write ports: wr0 (external load) beats wr1 (writeback) on an address clash.
// - Writes only land on the edge, so reads never see same-cycle write-through.
// - Addresses at or above NREG match no register, so writes to them are dropped.
module regfile_nx16 import alu_pkg::*; #(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd0_addr,
    output data_t         rd0_data,
    input  logic [AW-1:0] rd1_addr,
    output data_t         rd1_data,
    input  logic [AW-1:0] dbg_addr,
    output data_t         dbg_data,
    input  logic          wr0_en,
    input  logic [AW-1:0] wr0_addr,
    input  data_t         wr0_data,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr1_addr,
    input  data_t         wr1_data
);

    data_t mem_q [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            // One register: cleared by reset, load port written ahead of writeback.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (wr0_en && (wr0_addr == AW'(gi))) begin
                    mem_q[gi] <= wr0_data;
                end else if (wr1_en && (wr1_addr == AW'(gi))) begin
                    mem_q[gi] <= wr1_data;
                end
            end
        end
    endgenerate

    // Read muxes; an address with no matching register reads as zero.
    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        dbg_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd0_addr == AW'(i)) rd0_data = mem_q[i];
            if (rd1_addr == AW'(i)) rd1_data = mem_q[i];
            if (dbg_addr == AW'(i)) dbg_data = mem_q[i];
        end
    end

endmodule

// File: rtl/reg_issue_stage.sv
// Two-stage register-read / issue stage in front of an external combinational ALU.
// Cycle N: operands are read (with forwarding from the execute stage) and registered.
// Cycle N+1: the ALU result is shown on the wb_* outputs and written back at the edge.
// The external load port has priority: it stalls issue for the cycle it is used.
module reg_issue_stage import alu_pkg::*; #(
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    output logic [1:0]    alu_op,
    output logic [15:0]   alu_i0,
    output logic [15:0]   alu_i1,
    input  logic [15:0]   alu_o,
    input  logic          alu_cout,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [15:0]   wb_data,
    output logic          flag_c,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    // Execute-stage pipeline registers.
    logic          ex_valid_q, ex_valid_d;
    alu_op_e       alu_op_q,   alu_op_d;
    data_t         alu_i0_q,   alu_i0_d;
    data_t         alu_i1_q,   alu_i1_d;
    logic [AW-1:0] ex_rd_q,    ex_rd_d;
    logic          flag_c_q,   flag_c_d;

    data_t         rf_rs_data;
    data_t         rf_rt_data;
    data_t         opnd_a;
    data_t         opnd_b;
    logic          accept;
    logic          fwd_rs;
    logic          fwd_rt;

    regfile_nx16 #(
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_addr (in_rs),
        .rd0_data (rf_rs_data),
        .rd1_addr (in_rt),
        .rd1_data (rf_rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr0_en   (ld_en),
        .wr0_addr (ld_addr),
        .wr0_data (ld_data),
        .wr1_en   (ex_valid_q),
        .wr1_addr (ex_rd_q),
        .wr1_data (alu_o)
    );

    // Handshake and writeback view.
    // in_ready is held low during reset so every output reads zero.
    // The wb_* outputs are gated by the execute-valid bit, so they are quiet when idle.
    always_comb begin
        in_ready = rst_n & ~ld_en;
        accept   = in_valid & in_ready;
        wb_valid = ex_valid_q;
        wb_addr  = ex_valid_q ? ex_rd_q : '0;
        wb_data  = ex_valid_q ? alu_o   : '0;
    end

    // Operand forwarding.
    // The instruction in execute has not yet written the array,
    // so a matching source takes the live ALU result instead.
    always_comb begin
        fwd_rs = ex_valid_q && (in_rs == ex_rd_q);
        fwd_rt = ex_valid_q && (in_rt == ex_rd_q);
        opnd_a = fwd_rs ? alu_o : rf_rs_data;
        opnd_b = fwd_rt ? alu_o : rf_rt_data;
    end

    // Next state of the execute stage.
    // Operands only change on an accept; the valid bit tracks accept every cycle.
    always_comb begin
        ex_valid_d = accept;
        alu_op_d   = alu_op_q;
        alu_i0_d   = alu_i0_q;
        alu_i1_d   = alu_i1_q;
        ex_rd_d    = ex_rd_q;
        flag_c_d   = flag_c_q;
        if (accept) begin
            alu_op_d = alu_op_e'(in_op);
            alu_i0_d = opnd_a;
            alu_i1_d = opnd_b;
            ex_rd_d  = in_rd;
        end
        if (ex_valid_q) begin
            flag_c_d = alu_cout;
        end
    end

    // Pipeline state registers.
    // Reset discards any in-flight instruction and zeroes all driven operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            alu_op_q   <= OP_AND;
            alu_i0_q   <= '0;
            alu_i1_q   <= '0;
            ex_rd_q    <= '0;
            flag_c_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_op_q   <= alu_op_d;
            alu_i0_q   <= alu_i0_d;
            alu_i1_q   <= alu_i1_d;
            ex_rd_q    <= ex_rd_d;
            flag_c_q   <= flag_c_d;
        end
    end

    assign alu_op = alu_op_q;
    assign alu_i0 = alu_i0_q;
    assign alu_i1 = alu_i1_q;
    assign flag_c = flag_c_q;

endmodule

// File: tb/tb_reg_issue_stage.sv
// Self-checking bench for reg_issue_stage.
// - Supplies a behavioural ALU whose carry is the parity of (i0 ^ i1).
// - The reference model is architectural: every instruction completes in program
//   order at accept, and every load completes at its own edge.
// - Pipeline timing is applied only when observing outputs.
module tb_reg_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_i0, alu_i1, alu_o;
    logic        alu_cout;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flag_c;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_issue_stage #(.NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_c(flag_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // External ALU model.
    always_comb begin
        alu_o    = alu_ref(alu_op, alu_i0, alu_i1);
        alu_cout = ^(alu_i0 ^ alu_i1);
    end

    // Architectural reference state plus the instruction expected in execute.
    logic [15:0] arch [8];
    logic        pend_v;
    logic [2:0]  pend_rd;
    logic [1:0]  pend_op;
    logic [15:0] pend_a, pend_b, pend_res;
    logic        pend_cout;
    logic        exp_flag;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) arch[i] = 16'h0;
        pend_v = 0; pend_rd = 0; pend_op = 0; pend_a = 0; pend_b = 0;
        pend_res = 0; pend_cout = 0; exp_flag = 0;
    endtask

    // Advance the model over one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (pend_v) exp_flag = pend_cout;
        if (in_valid && !ld_en) begin
            pend_a    = arch[in_rs];
            pend_b    = arch[in_rt];
            pend_op   = in_op;
            pend_res  = alu_ref(in_op, pend_a, pend_b);
            pend_cout = ^(pend_a ^ pend_b);
            pend_rd   = in_rd;
            pend_v    = 1;
            arch[in_rd] = pend_res;
        end else begin
            pend_v = 0;
        end
        if (ld_en) arch[ld_addr] = ld_data;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; ld_en = 0;
    endtask

    task automatic set_ld(input logic [2:0] a, input logic [15:0] d);
        in_valid = 0; ld_en = 1; ld_addr = a; ld_data = d;
    endtask

    task automatic set_issue(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        ld_en = 0; in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 0;
        #7;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        ld_en = 1;
        rst_n = 0;
        #3;
        model_reset();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        n_checks++; if ({alu_op, alu_i0, alu_i1} !== 34'h0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_op, alu_i0, alu_i1); end
        n_checks++; if (flag_c !== 1'b0) begin n_fail++; $display("FAIL reset_flag_c: got %b expected 0", flag_c); end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_ld_hi: got %b expected 0", in_ready); end
        ld_en = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_ld_lo: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #0.1;
            n_checks++; if (dbg_data !== 16'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data); end
        end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_and_basic();
        set_ld(1, 16'h00FF); tick();
        set_ld(2, 16'h0F0F); tick();
        set_issue(OP_AND, 1, 2, 3); tick();
        set_idle();
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL and_wb_valid: got %b expected 1", wb_valid); end
        n_checks++; if (wb_addr !== 3'd3) begin n_fail++; $display("FAIL and_wb_addr: got %0d expected 3", wb_addr); end
        n_checks++; if (wb_data !== 16'h000F) begin n_fail++; $display("FAIL and_wb_data: got %h expected 000f", wb_data); end
        tick();
        dbg_addr = 3;
        @(negedge clk);
        n_checks++; if (dbg_data !== 16'h000F) begin n_fail++; $display("FAIL and_r3: got %h expected 000f", dbg_data); end
        tick();
        $display("test_and_basic: AND r3,r1,r2 -> %h", dbg_data);
    endtask

    task automatic test_forward();
        set_issue(OP_AND, 1, 2, 3); tick();
        set_issue(OP_OR, 3, 1, 4);
        @(negedge clk);
        n_checks++; if (wb_data !== 16'h000F) begin n_fail++; $display("FAIL fwd_first_wb: got %h expected 000f", wb_data); end
        tick();
        set_idle();
        @(negedge clk);
        n_checks++; if (alu_i0 !== 16'h000F) begin n_fail++; $display("FAIL fwd_alu_i0: got %h expected 000f", alu_i0); end
        n_checks++; if (alu_i1 !== 16'h00FF) begin n_fail++; $display("FAIL fwd_alu_i1: got %h expected 00ff", alu_i1); end
        n_checks++; if (wb_data !== 16'h00FF || wb_addr !== 3'd4) begin n_fail++; $display("FAIL fwd_second_wb: got %0d/%h expected 4/00ff", wb_addr, wb_data); end
        tick();
        dbg_addr = 4;
        @(negedge clk);
        n_checks++; if (dbg_data !== 16'h00FF) begin n_fail++; $display("FAIL fwd_r4: got %h expected 00ff", dbg_data); end
        tick();
        $display("test_forward: OR r4,r3,r1 -> %h", dbg_data);
    endtask

    task automatic test_rs_eq_rt();
        apply_reset();
        set_issue(OP_NOR, 0, 0, 5); tick();
        set_issue(OP_NAND, 5, 5, 6);
        @(negedge clk);
        n_checks++; if (wb_data !== 16'hFFFF) begin n_fail++; $display("FAIL nor_wb: got %h expected ffff", wb_data); end
        tick();
        set_idle();
        @(negedge clk);
        n_checks++; if (alu_i0 !== 16'hFFFF || alu_i1 !== 16'hFFFF) begin n_fail++; $display("FAIL nand_fwd_both: got %h %h expected ffff ffff", alu_i0, alu_i1); end
        n_checks++; if (wb_data !== 16'h0000) begin n_fail++; $display("FAIL nand_wb: got %h expected 0000", wb_data); end
        tick();
        dbg_addr = 5;
        #1;
        n_checks++; if (dbg_data !== 16'hFFFF) begin n_fail++; $display("FAIL nor_r5: got %h expected ffff", dbg_data); end
        dbg_addr = 6;
        #1;
        n_checks++; if (dbg_data !== 16'h0000) begin n_fail++; $display("FAIL nand_r6: got %h expected 0000", dbg_data); end
        tick();
        $display("test_rs_eq_rt: NOR r5 / NAND r6 done");
    endtask

    task automatic test_load_priority();
        set_ld(1, 16'hF0F0); tick();
        set_ld(2, 16'hFF00); tick();
        set_issue(OP_AND, 1, 2, 7); tick();
        // Load to r7 while the AND to r7 writes back; also try to issue (must be held off).
        set_ld(7, 16'h1234);
        in_valid = 1; in_op = OP_OR; in_rs = 1; in_rt = 2; in_rd = 0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ldpri_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 3'd7 || wb_data !== 16'hF000) begin n_fail++; $display("FAIL ldpri_wb: got %b/%0d/%h expected 1/7/f000", wb_valid, wb_addr, wb_data); end
        tick();
        set_idle();
        dbg_addr = 7;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldpri_no_issue: got %b expected 0", wb_valid); end
        n_checks++; if (dbg_data !== 16'h1234) begin n_fail++; $display("FAIL ldpri_r7: got %h expected 1234", dbg_data); end
        tick();
        $display("test_load_priority: r7 = %h", dbg_data);
    endtask

    task automatic test_reset_inflight();
        set_ld(3, 16'h0001); tick();
        set_ld(4, 16'h0000); tick();
        set_issue(OP_OR, 3, 4, 5); tick();
        set_issue(OP_OR, 3, 4, 2); tick();
        set_idle();
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b1 || flag_c !== 1'b1) begin n_fail++; $display("FAIL inflight_pre: got wb_valid %b flag_c %b expected 1 1", wb_valid, flag_c); end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++; if ({wb_valid, wb_addr, wb_data} !== 20'h0) begin n_fail++; $display("FAIL inflight_wb: got %b/%0d/%h expected 0/0/0000", wb_valid, wb_addr, wb_data); end
        n_checks++; if ({alu_op, alu_i0, alu_i1, flag_c, in_ready} !== 36'h0) begin n_fail++; $display("FAIL inflight_outs: got %h %h %h %b %b expected all 0", alu_op, alu_i0, alu_i1, flag_c, in_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        dbg_addr = 2;
        #1;
        n_checks++; if (dbg_data !== 16'h0000 || flag_c !== 1'b0) begin n_fail++; $display("FAIL inflight_after: got r2 %h flag_c %b expected 0000 0", dbg_data, flag_c); end
        $display("test_reset_inflight done");
    endtask

    // Random traffic checked cycle by cycle against the architectural model.
    task automatic test_random(input int cycles, input int ld_pct, input int vld_pct);
        for (int c = 0; c < cycles; c++) begin
            ld_en    = ($urandom_range(99) < ld_pct);
            ld_addr  = 3'($urandom_range(7));
            ld_data  = 16'($urandom);
            in_valid = ($urandom_range(99) < vld_pct);
            in_op    = 2'($urandom_range(3));
            in_rs    = (pend_v && $urandom_range(2) == 0) ? pend_rd : 3'($urandom_range(7));
            in_rt    = (pend_v && $urandom_range(2) == 0) ? pend_rd : 3'($urandom_range(7));
            in_rd    = 3'($urandom_range(7));
            dbg_addr = 3'($urandom_range(7));
            @(negedge clk);
            n_checks++; if (in_ready !== !ld_en) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, !ld_en); end
            n_checks++; if (wb_valid !== pend_v) begin n_fail++; $display("FAIL rnd_wb_valid c%0d: got %b expected %b", c, wb_valid, pend_v); end
            if (pend_v) begin
                n_checks++; if (wb_addr !== pend_rd || wb_data !== pend_res) begin n_fail++; $display("FAIL rnd_wb c%0d: got %0d/%h expected %0d/%h", c, wb_addr, wb_data, pend_rd, pend_res); end
            end
            n_checks++; if (alu_op !== pend_op || alu_i0 !== pend_a || alu_i1 !== pend_b) begin n_fail++; $display("FAIL rnd_alu c%0d: got %0d %h %h expected %0d %h %h", c, alu_op, alu_i0, alu_i1, pend_op, pend_a, pend_b); end
            n_checks++; if (flag_c !== exp_flag) begin n_fail++; $display("FAIL rnd_flag_c c%0d: got %b expected %b", c, flag_c, exp_flag); end
            if (!(pend_v && dbg_addr == pend_rd)) begin
                n_checks++; if (dbg_data !== arch[dbg_addr]) begin n_fail++; $display("FAIL rnd_dbg c%0d r%0d: got %h expected %h", c, dbg_addr, dbg_data, arch[dbg_addr]); end
            end
            if (in_valid && !ld_en) $display("cycle %0d issue op=%0d rs=%0d rt=%0d rd=%0d", c, in_op, in_rs, in_rt, in_rd);
            else if (ld_en) $display("cycle %0d load r%0d=%h", c, ld_addr, ld_data);
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
        model_reset();
        test_reset();
        test_and_basic();
        test_forward();
        test_rs_eq_rt();
        test_load_priority();
        test_reset_inflight();
        test_random(40, 0, 100);   // back-to-back issue, no loads
        test_random(400, 25, 70);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_issue_stage.md
REG_ISSUE_STAGE -- requirements
Module: reg_issue_stage

Interface
REQ-001 Parameter: NREG, 8, number of 16-bit registers; address width AW = log2(NREG).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; one clock domain.
REQ-004 in_valid  input  1  upstream presents an instruction.
REQ-005 in_ready  output  1  stage accepts an instruction this cycle.
REQ-006 in_op  input  2  ALU opcode: 00 AND, 01 OR, 10 NAND, 11 NOR.
REQ-007 in_rs, in_rt, in_rd  input  AW each  source A, source B and destination register.
REQ-008 ld_en, ld_addr, ld_data  input  1/AW/16  external register load port.
REQ-009 alu_op, alu_i0, alu_i1  output  2/16/16  registered operands driven to the ALU.
REQ-010 alu_o, alu_cout  input  16/1  combinational ALU result and carry returned.
REQ-011 wb_valid, wb_addr, wb_data  output  1/AW/16  writeback strobe, for observation.
REQ-012 flag_c  output  1  carry of the last written-back instruction.
REQ-013 dbg_addr  input  AW; dbg_data  output  16; combinational read of the register array.

Function
REQ-014 The block has a 2-stage pipeline; an instruction is accepted in cycle N when in_valid and in_ready are both high.
- At edge N: rs and rt are read, and alu_op, alu_i0, alu_i1 and the execute-valid bit are registered.
- During cycle N+1: the ALU evaluates.
- At edge N+1: alu_o is written to register rd, and alu_cout is written to flag_c.
REQ-015 wb_valid, wb_addr and wb_data are asserted combinationally during cycle N+1, while the execute stage holds a valid instruction.
REQ-016 in_ready is the inverse of ld_en; the load port always takes priority over issue.
REQ-017 When no instruction is accepted at an edge, the execute-valid bit clears and alu_* keep their previous values.
REQ-018 Forwarding applies when an accepted instruction reads a register equal to wb_addr while wb_valid is high: that operand takes alu_o, not the array value.
REQ-019 The forwarding check is done independently for rs and rt; if rs equals rt, both operands are forwarded.
REQ-020 When ld_en is high, ld_data is written to ld_addr at the edge.
REQ-021 If a load and a writeback target the same address in the same cycle, the load wins, because it is the younger operation.
REQ-022 A load and a writeback to different addresses in the same cycle both complete.
REQ-023 A register written at edge E is visible through the array and dbg_data from cycle E+1 onward; reads never see write-through within the same cycle except by the forwarding of REQ-018.
REQ-024 Writes to an address at or above NREG are ignored; this is only possible if NREG is not a power of two.
REQ-025 Back-to-back accepts sustain one instruction per cycle with no stall.

Reset
REQ-026 While rst_n is low, the following are zero regardless of clk:
- every register, alu_op, alu_i0 and alu_i1;
- the execute-valid bit and flag_c.
REQ-027 An instruction in flight when reset asserts is discarded and no writeback occurs; after rst_n deasserts, in_ready equals the inverse of ld_en.

Structure
REQ-028 The shared package alu_pkg holds the data width constant (16) and the opcode encodings OP_AND, OP_OR, OP_NAND and OP_NOR.
REQ-029 The register array is a sub-module regfile_nx16 with two combinational read ports, a third read port for debug, and two prioritised write ports (load over writeback).
REQ-030 The forwarding multiplexers and the pipeline registers reside in reg_issue_stage.

Verification
REQ-031 Load r1=0x00FF and r2=0x0F0F, then issue AND r3,r1,r2 -> wb_data=0x000F in the cycle after the accept, and dbg_data(r3)=0x000F one cycle later.
REQ-032 Issue AND r3,r1,r2 followed immediately by OR r4,r3,r1 -> the second instruction's alu_i0 is forwarded as 0x000F, and r4=0x00FF.
REQ-033 Immediately after reset, issue NOR r5,r0,r0 -> r5=0xFFFF; then NAND r6,r5,r5 -> r6=0x0000 via the rs=rt forward.
REQ-034 With AND r7 in execute, hold ld_en high to r7 with 0x1234 in that same cycle -> r7=0x1234, and in_ready is low for that cycle.
REQ-035 Pull rst_n low in the middle of cycle N+1 of an in-flight instruction -> no write to rd, all outputs 0 immediately, and flag_c=0.
